seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier: WIDTH-bit operands in, 2*WIDTH-bit product out.
- One multiplier bit is processed per clock, so a product takes WIDTH iteration cycles.
- Valid/ready handshakes on operand and result sides, plus synchronous abort.
- Sits as a co-processor between a request source and a result consumer; replaces the fixed 4x4 START/READY multiplier in the benchmark set.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous abort: discard any operation, return to IDLE.
- in_valid  input  1  operand pair a/b presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product p valid.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: one clock; rst_n asynchronous active-low.
  - State = IDLE; in_ready = 1; out_valid = 0; busy = 0; p = 0.
  - Accumulator, multiplicand register and counter = 0.
- State IDLE:
  - in_ready = 1.
  - in_valid & in_ready (with abort low) loads mcand <= a, acc <= 0, mq <= b, cnt <= 0, then goes to CALC.
- State CALC:
  - in_ready = 0; busy = 1.
  - Each cycle, with a (WIDTH+1)-bit add: sum = acc + (mq[0] ? mcand : 0).
  - {acc, mq} <= {sum, mq} >> 1, a logical shift of the (2*WIDTH+1)-bit concatenation.
  - cnt <= cnt + 1; cnt is $clog2(WIDTH+1) bits.
  - When cnt == WIDTH-1, the update completes and the state goes to DONE.
- State DONE:
  - out_valid = 1; p = {acc[WIDTH-1:0], mq}, registered and held stable.
  - out_valid & out_ready goes to IDLE; out_valid drops the next cycle.
  - While out_ready = 0, hold everything; no timeout.
- Latency:
  - Operand accept edge T.
  - out_valid rises after edge T+WIDTH, i.e. visible in cycle T+WIDTH+1.
  - Throughput: one product per WIDTH+2 cycles minimum (accept, WIDTH iterations, handoff).
- in_ready is combinational from state only; no path from in_valid to in_ready.
- in_valid while not in_ready is ignored; a/b need only be stable during the accepting cycle.
- abort:
  - Has priority over every transition, including a simultaneous accept or output handshake.
  - Next state IDLE; out_valid = 0 next cycle.
  - p keeps its last value; p is don't-care when out_valid = 0.
- Reset mid-operation: immediate return to reset values; the partial result is lost.
- Arithmetic:
  - Unsigned; the result is exact for all operands, with no overflow possible.
  - WIDTH'(0) operands still take the full WIDTH cycles; there is no early termination.
- p changes only on entry to DONE.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Adds port signed_mode (input, 1), sampled with a/b at accept and held in a register.
  - When signed_mode = 1, operands are two's complement; mcand is sign-extended to WIDTH+1 bits.
  - Right shift of acc is arithmetic.
  - On the final iteration (cnt == WIDTH-1), the block subtracts mcand instead of adding it when mq[0] = 1.
  - p is the exact 2*WIDTH two's-complement product.
  - When signed_mode = 0, behaviour is identical to the undefined case.
- Undefined:
  - No signed_mode port; unsigned only; no subtract path synthesised.

Test Plan:
- Reset, WIDTH=4: rst_n low with clk running -> in_ready=1, out_valid=0, busy=0, p=0; async: outputs clear before the next clk edge.
- WIDTH=4, a=13, b=11, out_ready=1 -> out_valid high exactly 5 cycles after the accept cycle, p=8'h8F (143); in_ready returns 1 one cycle later.
- WIDTH=4, a=15, b=15 then back-to-back a=0, b=9 -> p=8'hE1 (225) then 8'h00; in_valid during CALC is ignored (in_ready=0).
- Backpressure: a=7, b=6, out_ready=0 for 10 cycles -> out_valid and p=8'h2A held stable all 10 cycles; release -> out_valid drops the next cycle.
- Abort asserted in CALC cycle 2, then reset pulsed in a later CALC -> IDLE and out_valid=0 the next cycle with no stale result; reset clears asynchronously; a new op a=3, b=5 gives p=15.
- SEQ_MULT_SIGNED_EN, WIDTH=8: signed_mode=1, a=-8, b=7 -> p=16'hFFC8 (-56); a=-128, b=-128 -> 16'h4000; signed_mode=0, a=255, b=255 -> 16'hFE01.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: shift-add sequential multiplier, one multiplier bit per clock, valid/ready on both sides.
// Optional macro SEQ_MULT_SIGNED_EN adds a signed_mode input for two's-complement operands.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH + 1){1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_P   = {(2 * WIDTH){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     mcand_q, mcand_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic               shift_msb_s;
    logic               accept_s;
    logic               last_s;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_q, signed_d;
`endif

    assign accept_s = in_valid & in_ready_q & ~abort;
    assign last_s   = (state_q == S_CALC) && (cnt_q == CNT_LAST);

    // State and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) state_d = S_CALC;
                    else          state_d = S_IDLE;
                end
                S_CALC: begin
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                    else                   state_d = S_CALC;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                    else           state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from next state, so outputs come straight from flops
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_IDLE: in_ready_d = 1'b1;
            S_CALC: busy_d = 1'b1;
            S_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b1;
        endcase
    end

    // One iteration of the add/subtract and the widened sum
    always_comb begin
        if (mq_q[0]) addend_s = mcand_q;
        else         addend_s = ZERO_W1;
`ifdef SEQ_MULT_SIGNED_EN
        // Final multiplier bit carries negative weight in two's complement
        if (signed_q && (cnt_q == CNT_LAST)) sum_s = acc_q - addend_s;
        else                                 sum_s = acc_q + addend_s;
        shift_msb_s = signed_q & sum_s[WIDTH];
`else
        sum_s       = acc_q + addend_s;
        shift_msb_s = 1'b0;
`endif
    end

    // Datapath next values: load on accept, shift while calculating, else hold
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
`ifdef SEQ_MULT_SIGNED_EN
        signed_d = signed_q;
`endif
        if (accept_s) begin
`ifdef SEQ_MULT_SIGNED_EN
            mcand_d  = {signed_mode & a[WIDTH-1], a};
            signed_d = signed_mode;
`else
            mcand_d = {1'b0, a};
`endif
            acc_d = ZERO_W1;
            mq_d  = b;
            cnt_d = CNT_ZERO;
        end else if ((state_q == S_CALC) && !abort) begin
            acc_d = {shift_msb_s, sum_s[WIDTH:1]};
            mq_d  = {sum_s[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_ONE;
            if (last_s) p_d = {acc_d[WIDTH-1:0], mq_d};
            else        p_d = p_q;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= ZERO_W1;
            acc_q   <= ZERO_W1;
            mq_q    <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            p_q     <= ZERO_P;
`ifdef SEQ_MULT_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
            signed_q <= signed_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule
